// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic PORT_F = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 8;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; req[0] is port F, req[1] is port D.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // On a tie the port that did not win last time is chosen.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = PORT_F;
    case (req)
      2'b01:   gnt_id = PORT_F;
      2'b10:   gnt_id = PORT_D;
      2'b11:   gnt_id = ~last;
      default: gnt_id = PORT_F;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one RAM port between instruction fetch (F) and data (D) requesters.
// Optional abort-on-timeout in ACCESS is enabled with macro MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DWIDTH         = 16,
  parameter int AWIDTH         = 16,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [AWIDTH-1:0] f_addr,
  output logic              f_valid,
  output logic [DWIDTH-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_wen,
  input  logic [AWIDTH-1:0] d_addr,
  input  logic [DWIDTH-1:0] d_wdata,
  output logic              d_valid,
  output logic [DWIDTH-1:0] d_rdata,
  output logic              err,
  output logic              ram_en,
  output logic              wen,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata,
  input  logic              ram_valid
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t state_r, state_s;
  logic   last_r;
  logic   owner_r;
  logic   gnt_valid_s;
  logic   gnt_id_s;
  logic   expire_s;

  rr_pick2 u_pick (
    .req       ({d_req, f_req}),
    .last      (last_r),
    .gnt_valid (gnt_valid_s),
    .gnt_id    (gnt_id_s)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_r;

  // Counts ACCESS cycles; cleared while idle so each transaction starts at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (state_r == ACCESS) begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  assign expire_s = (state_r == ACCESS) && (cnt_r == CW'(TIMEOUT_CYCLES - 1));
`else
  assign expire_s = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) state_s = ACCESS;
        else             state_s = IDLE;
      end
      ACCESS: begin
        if (ram_valid || expire_s) state_s = DONE;
        else                       state_s = ACCESS;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      last_r    <= PORT_F;
      owner_r   <= PORT_F;
      ram_en    <= 1'b0;
      wen       <= 1'b0;
      ram_addr  <= {AWIDTH{1'b0}};
      ram_wdata <= {DWIDTH{1'b0}};
      f_valid   <= 1'b0;
      d_valid   <= 1'b0;
      f_rdata   <= {DWIDTH{1'b0}};
      d_rdata   <= {DWIDTH{1'b0}};
      err       <= 1'b0;
    end else begin
      state_r <= state_s;
      f_valid <= 1'b0;
      d_valid <= 1'b0;
      err     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (gnt_valid_s) begin
            owner_r   <= gnt_id_s;
            last_r    <= gnt_id_s;
            ram_en    <= 1'b1;
            wen       <= (gnt_id_s == PORT_D) ? d_wen : 1'b0;
            ram_addr  <= (gnt_id_s == PORT_D) ? d_addr : f_addr;
            ram_wdata <= (gnt_id_s == PORT_D) ? d_wdata : {DWIDTH{1'b0}};
          end
        end
        ACCESS: begin
          // Real completion wins over a simultaneous timeout.
          if (ram_valid) begin
            ram_en <= 1'b0;
            wen    <= 1'b0;
            if (owner_r == PORT_D) begin
              d_valid <= 1'b1;
              if (!wen) d_rdata <= ram_rdata;
            end else begin
              f_valid <= 1'b1;
              f_rdata <= ram_rdata;
            end
          end else if (expire_s) begin
            ram_en <= 1'b0;
            wen    <= 1'b0;
            err    <= 1'b1;
            if (owner_r == PORT_D) begin
              d_valid <= 1'b1;
              d_rdata <= {DWIDTH{1'b0}};
            end else begin
              f_valid <= 1'b1;
              f_rdata <= {DWIDTH{1'b0}};
            end
          end
        end
        DONE: begin
          ram_en <= 1'b0;
          wen    <= 1'b0;
        end
        default: begin
          ram_en <= 1'b0;
          wen    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; timeout steps follow MEM_ARB_TIMEOUT_EN.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_req, d_req, d_wen, ram_valid;
  logic [15:0] f_addr, d_addr, d_wdata, ram_rdata;
  logic        f_valid, d_valid, err, ram_en, wen;
  logic [15:0] f_rdata, d_rdata, ram_addr, ram_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_valid   (f_valid),
    .f_rdata   (f_rdata),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_valid   (d_valid),
    .d_rdata   (d_rdata),
    .err       (err),
    .ram_en    (ram_en),
    .wen       (wen),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .ram_valid (ram_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; f_req = 1'b0; d_req = 1'b0; d_wen = 1'b0; ram_valid = 1'b0;
    f_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0; ram_rdata = 16'h0;
    tick(); tick();
    chk("rst_ram_en", ram_en, 0);   chk("rst_wen", wen, 0);
    chk("rst_addr", ram_addr, 0);   chk("rst_wdata", ram_wdata, 0);
    chk("rst_fv", f_valid, 0);      chk("rst_dv", d_valid, 0);
    chk("rst_frd", f_rdata, 0);     chk("rst_drd", d_rdata, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;

    // Fetch with two wait cycles
    f_req = 1'b1; f_addr = 16'h0010;
    tick();
    chk("f_en1", ram_en, 1); chk("f_wen", wen, 0); chk("f_addr", ram_addr, 16'h0010);
    tick(); chk("f_en2", ram_en, 1); chk("f_fv_wait", f_valid, 0);
    tick(); chk("f_en3", ram_en, 1);
    ram_valid = 1'b1; ram_rdata = 16'hBEEF;
    tick();
    chk("f_valid", f_valid, 1); chk("f_rdata", f_rdata, 16'hBEEF);
    chk("f_en_done", ram_en, 0); chk("f_dv", d_valid, 0);
    f_req = 1'b0; ram_valid = 1'b0;
    tick();
    chk("f_valid_drop", f_valid, 0); chk("f_rdata_hold", f_rdata, 16'hBEEF);

    // Data write, immediate completion
    d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0042; d_wdata = 16'h1234;
    tick();
    chk("w_en", ram_en, 1); chk("w_wen", wen, 1);
    chk("w_addr", ram_addr, 16'h0042); chk("w_wdata", ram_wdata, 16'h1234);
    ram_valid = 1'b1; ram_rdata = 16'h5555;
    tick();
    chk("w_dvalid", d_valid, 1); chk("w_drd_unch", d_rdata, 16'h0000);
    chk("w_wen_done", wen, 0); chk("w_fv", f_valid, 0);
    d_req = 1'b0; d_wen = 1'b0; ram_valid = 1'b0;
    tick(); chk("w_dv_drop", d_valid, 0);

    // Data read
    d_req = 1'b1; d_addr = 16'h0007;
    tick(); chk("r_wen", wen, 0); chk("r_addr", ram_addr, 16'h0007);
    ram_valid = 1'b1; ram_rdata = 16'hA5A5;
    tick(); chk("r_dvalid", d_valid, 1); chk("r_drd", d_rdata, 16'hA5A5);
    d_req = 1'b0; ram_valid = 1'b0;
    tick();

    // ram_valid while idle is ignored
    ram_valid = 1'b1; ram_rdata = 16'hFFFF;
    tick();
    chk("idle_rv_en", ram_en, 0); chk("idle_rv_fv", f_valid, 0);
    chk("idle_rv_dv", d_valid, 0); chk("idle_rv_drd", d_rdata, 16'hA5A5);
    ram_valid = 1'b0;
    tick(); chk("idle_rv_en2", ram_en, 0);

    // Round robin after reset: D, F, D, F
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    f_req = 1'b1; d_req = 1'b1; d_wen = 1'b0; f_addr = 16'h0100; d_addr = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      logic exp_d;
      exp_d = (i % 2 == 0);
      tick();
      chk("rr_en", ram_en, 1);
      chk("rr_addr", ram_addr, exp_d ? 16'h0200 : 16'h0100);
      ram_valid = 1'b1; ram_rdata = 16'h1000 + 16'(i);
      tick();
      chk("rr_dv", d_valid, exp_d); chk("rr_fv", f_valid, !exp_d);
      if (exp_d) chk("rr_drd", d_rdata, 16'h1000 + 16'(i));
      else       chk("rr_frd", f_rdata, 16'h1000 + 16'(i));
      ram_valid = 1'b0;
      tick();
      chk("rr_idle_en", ram_en, 0); chk("rr_idle_dv", d_valid, 0); chk("rr_idle_fv", f_valid, 0);
    end
    f_req = 1'b0; d_req = 1'b0;
    tick();

    // Reset during ACCESS abandons the transaction
    f_req = 1'b1; f_addr = 16'h0055;
    tick(); chk("mr_en", ram_en, 1);
    rst_n = 1'b0; f_req = 1'b0; ram_valid = 1'b1; ram_rdata = 16'h9999;
    tick();
    chk("mr_en_rst", ram_en, 0); chk("mr_fv", f_valid, 0); chk("mr_dv", d_valid, 0);
    rst_n = 1'b1; ram_valid = 1'b0;
    tick();
    chk("mr_en_after", ram_en, 0); chk("mr_fv_after", f_valid, 0); chk("mr_frd", f_rdata, 0);

    // Preload d_rdata, then a read that the RAM never answers
    d_req = 1'b1; d_wen = 1'b0; d_addr = 16'h0033;
    tick(); ram_valid = 1'b1; ram_rdata = 16'h7777;
    tick(); chk("pre_drd", d_rdata, 16'h7777);
    ram_valid = 1'b0; d_req = 1'b0;
    tick();
    d_req = 1'b1;
    tick(); chk("to_en1", ram_en, 1);
    d_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("to_en_wait", ram_en, 1); chk("to_dv_wait", d_valid, 0); chk("to_err_wait", err, 0);
    end
    tick();
    chk("to_err", err, 1); chk("to_dv", d_valid, 1);
    chk("to_drd", d_rdata, 16'h0000); chk("to_en_off", ram_en, 0);
    tick();
    chk("to_err_drop", err, 0); chk("to_dv_drop", d_valid, 0);
`else
    for (int i = 0; i < 20; i++) tick();
    chk("nto_en", ram_en, 1); chk("nto_dv", d_valid, 0);
    chk("nto_err", err, 0); chk("nto_drd", d_rdata, 16'h7777);
    ram_valid = 1'b1; ram_rdata = 16'h4321;
    tick();
    chk("nto_late_dv", d_valid, 1); chk("nto_late_drd", d_rdata, 16'h4321);
    ram_valid = 1'b0;
    tick(); chk("nto_dv_drop", d_valid, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
